// File: rtl/mux_sync_pkg.sv
// ============================================================================
// Module : mux_sync_pkg
// Brief  : Shared FSM encoding and default sizing for the mux-sync arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mux_sync_pkg;

    localparam int c_def_num_req = 4;
    localparam int c_def_data_w  = 8;
    localparam int c_def_timeout = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, searching upward from pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_sync_pkg::*;
#(
    parameter int NUM_REQ = c_def_num_req,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // pointer + k is below 2*NUM_REQ, so one subtraction wraps it
            w_sum = {1'b0, pointer} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!valid && req[w_idx]) begin
                valid         = 1'b1;
                grant[w_idx]  = 1'b1;
                winner        = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_sync_arbiter.sv
// ============================================================================
// Module : mux_sync_arbiter
// Brief  : Round-robin owner of a recirculation-mux synchronizer with
//          enable/ack four-phase handshake and per-edge timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux_sync_arbiter
    import mux_sync_pkg::*;
#(
    parameter int NUM_REQ = c_def_num_req,
    parameter int DATA_W  = c_def_data_w,
    parameter int TIMEOUT = c_def_timeout
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      ack_sync,
    output logic [DATA_W-1:0]         xfer_data,
    output logic                      xfer_enable,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int               c_ptr_w   = ptr_width(NUM_REQ);
    localparam int               c_cnt_w   = $clog2(TIMEOUT) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(NUM_REQ - 1);

    state_t              r_state, w_state_nxt;
    logic [c_ptr_w-1:0]  r_ptr, w_ptr_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_xfer_data, w_data_nxt;
    logic                r_enable, w_enable_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]  r_done, w_done_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_err, w_err_nxt;

    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [c_ptr_w-1:0]  w_arb_winner;
    logic                w_arb_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_timed_out;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_arbiter (
        .req     (req),
        .pointer (r_ptr),
        .grant   (w_arb_grant),
        .winner  (w_arb_winner),
        .valid   (w_arb_valid)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_grant[i]) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timed_out = (r_cnt == c_cnt_max);

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_xfer_data;
        w_enable_nxt = r_enable;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_busy_nxt   = r_busy;
        w_err_nxt    = r_err;
        case (r_state)
            ST_IDLE: begin
                // A still-high ack belongs to an old handshake; wait it out
                if (w_arb_valid && !ack_sync) begin
                    w_state_nxt  = ST_SEND;
                    w_ptr_nxt    = (w_arb_winner == c_last) ? '0 : w_arb_winner + 1'b1;
                    w_cnt_nxt    = '0;
                    w_data_nxt   = w_sel_data;
                    w_enable_nxt = 1'b1;
                    w_grant_nxt  = w_arb_grant;
                    w_busy_nxt   = 1'b1;
                end
            end
            ST_SEND: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (ack_sync) begin
                    w_state_nxt  = ST_RELEASE;
                    w_cnt_nxt    = '0;
                    w_enable_nxt = 1'b0;
                end else if (w_timed_out) begin
                    w_state_nxt  = ST_IDLE;
                    w_err_nxt    = 1'b1;
                    w_enable_nxt = 1'b0;
                    w_grant_nxt  = '0;
                    w_busy_nxt   = 1'b0;
                end
            end
            ST_RELEASE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (!ack_sync) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = r_grant;
                end else if (w_timed_out) begin
                    w_state_nxt  = ST_IDLE;
                    w_err_nxt    = 1'b1;
                    w_enable_nxt = 1'b0;
                    w_grant_nxt  = '0;
                    w_busy_nxt   = 1'b0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_xfer_data <= '0;
            r_enable    <= 1'b0;
            r_grant     <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_xfer_data <= w_data_nxt;
            r_enable    <= w_enable_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign xfer_data   = r_xfer_data;
    assign xfer_enable = r_enable;
    assign grant       = r_grant;
    assign done        = r_done;
    assign busy        = r_busy;
    assign timeout_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mux_sync_arbiter.sv
// ============================================================================
// Module : tb_mux_sync_arbiter
// Brief  : Directed vector table plus hand sequences for mux_sync_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mux_sync_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        ack_sync;
    logic [7:0]  xfer_data;
    logic        xfer_enable;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    mux_sync_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack_sync    (ack_sync),
        .xfer_data   (xfer_data),
        .xfer_enable (xfer_enable),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          ack_delay;
        int          ack_hold;
        bit          drop;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int limit);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 4'b0 && n < limit);
    endtask

    task automatic finish_xfer(input string name, input logic [3:0] exp);
        ack_sync = 1'b1;
        tick();
        ack_sync = 1'b0;
        tick();
        check({name, "_done"}, done, exp);
        tick();
        check({name, "_idle"}, {done, grant, busy, xfer_enable}, 0);
    endtask

    task automatic run_xfer(input int idx, input vec_t v);
        bit ok;
        string tag;
        tag = $sformatf("v%0d", idx);
        req      = v.req;
        req_data = v.data;
        wait_grant(10);
        check({tag, "_grant"}, grant, v.exp_grant);
        if (grant == 4'b0) return;
        check({tag, "_data"}, xfer_data, v.exp_data);
        check({tag, "_busy_en"}, {busy, xfer_enable}, 2'b11);
        if (v.drop) req = 4'b0;
        ok = 1'b1;
        for (int i = 0; i < v.ack_delay; i++) begin
            tick();
            if (xfer_enable !== 1'b1 || xfer_data !== v.exp_data || done !== 4'b0) ok = 1'b0;
        end
        check({tag, "_send_hold"}, ok, 1);
        ack_sync = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < v.ack_hold; i++) begin
            tick();
            if (xfer_enable !== 1'b0 || done !== 4'b0 || grant !== v.exp_grant ||
                xfer_data !== v.exp_data || busy !== 1'b1) ok = 1'b0;
        end
        check({tag, "_release"}, ok, 1);
        ack_sync = 1'b0;
        tick();
        check({tag, "_done"}, done, v.exp_grant);
        tick();
        check({tag, "_idle"}, {done, grant, busy, xfer_enable}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit saw_done;
        int n;

        // Pointer after each row is noted; rows depend on the previous row.
        vecs[0]  = '{4'b1111, 32'h4433_2211, 0, 1, 1'b0, 4'b0001, 8'h11}; // ptr 1
        vecs[1]  = '{4'b1111, 32'h4433_2211, 0, 1, 1'b0, 4'b0010, 8'h22}; // ptr 2
        vecs[2]  = '{4'b1111, 32'h4433_2211, 0, 1, 1'b0, 4'b0100, 8'h33}; // ptr 3
        vecs[3]  = '{4'b1111, 32'h4433_2211, 0, 1, 1'b0, 4'b1000, 8'h44}; // ptr 0
        vecs[4]  = '{4'b1111, 32'h4433_2211, 0, 1, 1'b0, 4'b0001, 8'h11}; // ptr 1
        vecs[5]  = '{4'b0001, 32'h0000_00A5, 5, 3, 1'b0, 4'b0001, 8'hA5}; // ptr 1
        vecs[6]  = '{4'b1010, 32'hDEAD_BEEF, 2, 1, 1'b0, 4'b0010, 8'hBE}; // ptr 2
        vecs[7]  = '{4'b1001, 32'hDEAD_BEEF, 0, 1, 1'b0, 4'b1000, 8'hDE}; // ptr 0
        vecs[8]  = '{4'b0100, 32'h00C3_0000, 3, 2, 1'b0, 4'b0100, 8'hC3}; // ptr 3
        vecs[9]  = '{4'b0011, 32'h0000_5A3C, 1, 1, 1'b0, 4'b0001, 8'h3C}; // ptr 1
        vecs[10] = '{4'b0100, 32'h0077_0000, 1, 1, 1'b1, 4'b0100, 8'h77}; // ptr 3

        reset    = 1'b1;
        req      = 4'b0;
        req_data = 32'h0;
        ack_sync = 1'b0;
        tick();
        tick();
        check("reset_outputs", {xfer_data, xfer_enable, grant, done, busy, timeout_err}, 0);
        reset = 1'b0;
        tick();
        check("idle_no_req", {grant, busy, xfer_enable}, 0);

        for (int i = 0; i < 11; i++) begin
            run_xfer(i, vecs[i]);
        end

        // Timeout: requester 1 never acknowledged, pointer then sits at 2.
        req      = 4'b0010;
        req_data = 32'h0000_9900;
        wait_grant(10);
        check("to_grant", grant, 4'b0010);
        check("to_data", xfer_data, 8'h99);
        ok = 1'b1;
        saw_done = 1'b0;
        n = 0;
        while (busy && n < 80) begin
            if (xfer_enable !== 1'b1) ok = 1'b0;
            tick();
            n++;
            if (done !== 4'b0) saw_done = 1'b1;
        end
        check("to_cycles", n, 64);
        check("to_enable_held", ok, 1);
        check("to_state", {timeout_err, xfer_enable, grant, busy}, 7'b1_0_0000_0);
        check("to_no_done", saw_done, 0);
        req = 4'b0110;
        wait_grant(10);
        check("to_next_grant", grant, 4'b0100);
        check("to_err_sticky", timeout_err, 1);
        finish_xfer("to_next", 4'b0100);                                   // ptr 3

        // Reset while in RELEASE discards the transfer and the pointer.
        req      = 4'b1111;
        req_data = 32'h4433_2211;
        wait_grant(10);
        check("rr_grant", grant, 4'b1000);
        ack_sync = 1'b1;
        tick();
        check("rr_release", {xfer_enable, busy}, 2'b01);
        reset    = 1'b1;
        ack_sync = 1'b0;
        tick();
        check("rr_all_zero", {xfer_data, xfer_enable, grant, done, busy, timeout_err}, 0);
        reset = 1'b0;
        tick();
        check("rr_ptr_zero", grant, 4'b0001);
        finish_xfer("rr_after", 4'b0001);                                  // ptr 1

        // Stale ack in IDLE blocks arbitration until it drops.
        ack_sync = 1'b1;
        req      = 4'b0100;
        req_data = 32'h0061_0000;
        ok = 1'b1;
        repeat (4) begin
            tick();
            if (grant !== 4'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check("stale_blocked", ok, 1);
        ack_sync = 1'b0;
        tick();
        check("stale_grant", grant, 4'b0100);
        check("stale_data", xfer_data, 8'h61);
        finish_xfer("stale", 4'b0100);

        req = 4'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
